fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `sync_fifo` write port between `NREQ` producers. It grants one producer at a time for a burst of up to `BURST` words. It drives the FIFO's `wr_en`/`wdata` and watches its `full` flag, so a write is never issued into a full FIFO and `overflow` is never raised by arbitrated traffic. It sits directly in front of `sync_fifo` in the same clock domain.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write-port arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata_in;
    logic                  fifo_full;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  stall;
    logic [IDXW-1:0]       owner;

    // master: producers plus FIFO status; slave: the arbiter itself
    modport master (
        output req, wdata_in, fifo_full,
        input  gnt, fifo_wr_en, fifo_wdata, stall, owner
    );

    modport slave (
        input  req, wdata_in, fifo_full,
        output gnt, fifo_wr_en, fifo_wdata, stall, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers, with bursts of up to
// BURST words per grant and no write ever issued while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input logic              clk,
    input logic              res,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = $clog2(BURST) + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IDXW-1:0] r_rr_ptr;
    logic [IDXW-1:0] r_owner;
    logic [CNTW-1:0] r_cnt;

    logic            w_grant;
    logic            w_req_own;
    logic            w_wr;
    logic [CNTW-1:0] w_cnt_inc;
    logic [IDXW-1:0] w_next_ptr;
    logic            w_found;
    logic [IDXW-1:0] w_sel;
    logic [IDXW:0]   w_idx;

    assign w_grant    = (r_state == StGrant);
    assign w_req_own  = bus.req[r_owner];
    assign w_wr       = w_grant & w_req_own & ~bus.fifo_full & ~res;
    assign w_cnt_inc  = r_cnt + CNTW'(1);
    assign w_next_ptr = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);

    // First requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDXW + 1)'(i);
            if (w_idx >= (IDXW + 1)'(NREQ)) begin
                w_idx = w_idx - (IDXW + 1)'(NREQ);
            end
            if (!w_found && bus.req[w_idx[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_owner <= w_sel;
                        r_gnt   <= {{(NREQ - 1){1'b0}}, 1'b1} << w_sel;
                        r_cnt   <= '0;
                        r_state <= StGrant;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                StGrant: begin
                    if (w_wr) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNTW'(BURST)) begin
                            r_gnt    <= '0;
                            r_state  <= StIdle;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else if (!w_req_own) begin
                        // producer withdrew: release without writing this cycle
                        r_gnt    <= '0;
                        r_state  <= StIdle;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.owner      = r_owner;
    assign bus.fifo_wr_en = w_wr;
    assign bus.fifo_wdata = (w_grant && !res) ? bus.wdata_in[r_owner*WIDTH +: WIDTH] : '0;
    assign bus.stall      = w_grant & w_req_own & bus.fifo_full & ~res;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin bursts, full stall, early release,
// wrap-around and mid-burst reset.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic res;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    fifo_wr_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST(4)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input int p);
        check("burst_gnt", 32'(bus.gnt), 32'(4'b0001 << p));
        check("burst_wr_en", 32'(bus.fifo_wr_en), 32'd1);
        check("burst_wdata", 32'(bus.fifo_wdata), 32'(exp_data[p]));
        check("burst_owner", 32'(bus.owner), 32'(p));
    endtask

    initial begin
        res          = 1'b1;
        bus.req      = 4'hF;
        bus.fifo_full = 1'b0;
        bus.wdata_in = 32'h4433_2211;

        // Reset held two edges with everyone requesting
        tick();
        tick();
        settle();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_wdata", 32'(bus.fifo_wdata), 32'd0);

        res = 1'b0;
        settle();
        check("idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        tick();

        // Round-robin 0,1,2,3,0: four writes each, one idle cycle between
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                check_write(b % 4);
                tick();
            end
            check("rr_gap_gnt", 32'(bus.gnt), 32'd0);
            check("rr_gap_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            tick();
        end

        // Producer 1 granted; two writes then the FIFO fills
        check_write(1);
        tick();
        check_write(1);
        tick();
        bus.fifo_full = 1'b1;
        settle();
        check("full_stall", 32'(bus.stall), 32'd1);
        check("full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("full_gnt", 32'(bus.gnt), 32'b0010);
        tick();
        check("full_stall2", 32'(bus.stall), 32'd1);
        check("full_wr_en2", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        check("full_hold_gnt", 32'(bus.gnt), 32'b0010);
        bus.fifo_full = 1'b0;
        settle();
        check("resume_stall", 32'(bus.stall), 32'd0);
        check_write(1);
        tick();
        check_write(1);
        tick();
        // Count resumed from 2, so exactly two more writes end the burst
        check("full_release_gnt", 32'(bus.gnt), 32'd0);
        tick();

        // Producer 2 drops after two writes
        check_write(2);
        tick();
        check_write(2);
        tick();
        bus.req = 4'b1011;
        settle();
        check("drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("drop_stall", 32'(bus.stall), 32'd0);
        tick();
        check("drop_release_gnt", 32'(bus.gnt), 32'd0);
        tick();
        check("after_drop_gnt", 32'(bus.gnt), 32'b1000);
        check("after_drop_owner", 32'(bus.owner), 32'd3);

        // Only 3 and 0 requesting: 3, 0, 3
        bus.req = 4'b1001;
        settle();
        for (int w = 0; w < 4; w++) begin
            check_write(3);
            tick();
        end
        check("wrap_gap_gnt", 32'(bus.gnt), 32'd0);
        tick();
        for (int w = 0; w < 4; w++) begin
            check_write(0);
            tick();
        end
        check("wrap_gap2_gnt", 32'(bus.gnt), 32'd0);
        tick();
        check("wrap_back_gnt", 32'(bus.gnt), 32'b1000);
        check("wrap_back_owner", 32'(bus.owner), 32'd3);

        // Steer to producer 2, then reset during its third write cycle
        bus.req = 4'b0100;
        settle();
        check("steer_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        check("steer_idle_gnt", 32'(bus.gnt), 32'd0);
        tick();
        check_write(2);
        tick();
        check_write(2);
        tick();
        res     = 1'b1;
        bus.req = 4'b0110;
        settle();
        check("mid_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("mid_rst_wdata", 32'(bus.fifo_wdata), 32'd0);
        check("mid_rst_stall", 32'(bus.stall), 32'd0);
        tick();
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_owner", 32'(bus.owner), 32'd0);
        res = 1'b0;
        tick();
        check("post_rst_gnt", 32'(bus.gnt), 32'b0010);
        check("post_rst_owner", 32'(bus.owner), 32'd1);
        check("post_rst_wr_en", 32'(bus.fifo_wr_en), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
